monitor_snapshot_reader: RTL and testbench

Downstream consumer of the event monitor's count/count_valid outputs. On a software/host request it waits until the monitor reports a settled count, captures it, and computes the delta since the previous capture. It then streams both values out as fixed-width words on a valid/ready interface toward the host readout path. A bounded wait aborts with a timeout flag if the monitor never settles.

---
 rtl/monitor_snapshot_reader.sv | 114 +++++++++++
 tb/tb_monitor_snapshot_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/monitor_snapshot_reader.sv
// Captures a settled monitor count on request, computes the delta since the previous
// capture and streams {delta, snapshot} as LSB-first words over valid/ready.
module monitor_snapshot_reader #(
  parameter int COUNTER_WIDTH = 64,
  parameter int OUT_WIDTH     = 16,
  parameter int MAX_WAIT      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     busy,
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic                     count_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_last,
  output logic                     timeout
);

  localparam int N      = COUNTER_WIDTH / OUT_WIDTH;
  localparam int WORDS  = 2 * N;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

  generate
    if (COUNTER_WIDTH % OUT_WIDTH != 0) begin : g_width_check
      $error("COUNTER_WIDTH (%0d) must be a multiple of OUT_WIDTH (%0d)", COUNTER_WIDTH, OUT_WIDTH);
    end
    if (MAX_WAIT < 1) begin : g_wait_check
      $error("MAX_WAIT (%0d) must be at least 1", MAX_WAIT);
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] prev_r, snap_r, delta_r;
  logic [IDX_W-1:0]         idx;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     capture, expire, accept;
  logic [2*COUNTER_WIDTH-1:0] frame;

  // A settled count takes priority over the wait limit on the same edge.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    expire     = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: if (req) state_next = S_WAIT;
      S_WAIT: begin
        if (count_valid) begin
          capture    = 1'b1;
          state_next = S_SEND;
        end else if (wait_cnt == WAIT_LIMIT) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          accept = 1'b1;
          if (idx == LAST_IDX) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timeout  <= 1'b0;
      wait_cnt <= '0;
      idx      <= '0;
      prev_r   <= '0;
      snap_r   <= '0;
      delta_r  <= '0;
    end else begin
      state   <= state_next;
      timeout <= expire;
      if (state == S_IDLE && req)
        wait_cnt <= '0;
      else if (state == S_WAIT && !count_valid && !expire)
        wait_cnt <= wait_cnt + 1'b1;
      if (capture) begin
        snap_r  <= count;
        delta_r <= count - prev_r;
        prev_r  <= count;
        idx     <= '0;
      end else if (accept && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs decode registered state only; snapshot words precede delta words.
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_SEND);
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign frame     = {delta_r, snap_r};

  always_comb begin
    out_data = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (out_valid && idx == IDX_W'(k))
        out_data = frame[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_monitor_snapshot_reader.sv
// Directed bench for monitor_snapshot_reader: capture, delta, wrap, backpressure,
// timeout and asynchronous reset mid-frame.
module tb_monitor_snapshot_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        busy;
  logic [63:0] count;
  logic        count_valid;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        timeout;

  int passed = 0;
  int total  = 0;

  monitor_snapshot_reader #(
    .COUNTER_WIDTH(64),
    .OUT_WIDTH    (16),
    .MAX_WAIT     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
    .count      (count),
    .count_valid(count_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called 1 time unit after a rising edge with the DUT idle; returns with word 0 on the bus.
  task automatic start_capture(input logic [63:0] c);
    count       = c;
    count_valid = 1'b1;
    req         = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("wait_busy", {63'd0, busy}, 64'd1);
    check("wait_no_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic recv_frame(input string tag, input logic [63:0] s, input logic [63:0] d,
                            input int pct, input bit poke_req);
    logic [127:0] frame;
    int words;
    int cycles;
    frame  = {d, s};
    words  = 0;
    cycles = 0;
    while (words < 8 && cycles < 200) begin
      out_ready = ($urandom_range(0, 99) < pct);
      if (poke_req) req = ($urandom_range(0, 1) == 1);
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_data"}, {48'd0, out_data}, {48'd0, frame[words*16 +: 16]});
      check({tag, "_last"}, {63'd0, out_last}, (words == 7) ? 64'd1 : 64'd0);
      if (out_ready) words++;
      @(posedge clk); #1;
      cycles++;
    end
    req       = 1'b0;
    out_ready = 1'b0;
    check({tag, "_words"}, 64'(words), 64'd8);
    check({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    req         = 1'b0;
    count       = '0;
    count_valid = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    check("rst_data", {48'd0, out_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", {63'd0, busy}, 64'd0);

    // First capture: delta equals the count itself.
    start_capture(64'h1234);
    recv_frame("t1", 64'h1234, 64'h1234, 100, 1'b0);

    start_capture(64'h1300);
    recv_frame("t2", 64'h1300, 64'h00CC, 100, 1'b0);

    // Modular wrap of the delta.
    start_capture(64'hFFFF_FFFF_FFFF_FFF0);
    recv_frame("t3a", 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_ECF0, 100, 1'b0);
    start_capture(64'h10);
    recv_frame("t3b", 64'h10, 64'h20, 100, 1'b0);

    // Backpressure with stray requests during the frame.
    start_capture(64'h35);
    recv_frame("t4", 64'h35, 64'h25, 30, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("t4_no_extra_frame", {63'd0, busy}, 64'd0);
    end

    // Timeout: 16 WAIT edges with count_valid low.
    count_valid = 1'b0;
    count       = 64'hDEAD;
    req         = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      check("t5_wait_timeout", {63'd0, timeout}, 64'd0);
      check("t5_wait_busy", {63'd0, busy}, 64'd1);
      check("t5_wait_valid", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    check("t5_timeout_pulse", {63'd0, timeout}, 64'd1);
    check("t5_timeout_idle", {63'd0, busy}, 64'd0);
    check("t5_timeout_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("t5_timeout_end", {63'd0, timeout}, 64'd0);
    start_capture(64'h50);
    recv_frame("t5", 64'h50, 64'h1B, 100, 1'b0);

    // Asynchronous reset after three accepted words.
    start_capture(64'h99);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t6_pre_data", {48'd0, out_data}, (k == 0) ? 64'h99 : (k == 1 || k == 2) ? 64'd0 : 64'd0);
      @(posedge clk); #1;
    end
    check("t6_mid_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_data", {48'd0, out_data}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t6_post_busy", {63'd0, busy}, 64'd0);
    start_capture(64'h40);
    recv_frame("t6", 64'h40, 64'h40, 100, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
